forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Pipelined forwarding and load-use hazard controller for the 5-stage RV32 core. It tracks destination-register tags for the instructions in EX, MEM and WB, and produces the registered 2-bit forward selects that drive the EX-stage operand muxes. The selects are `00` = register file, `01` = WB write data and `10` = MEM ALU result. It also raises the load-use stall toward the IF/ID stages.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `CNT_W`, 32: stall-counter width.

Ports:
- `clk_i`, input, 1: core clock, rising edge.
- `rst_i`, input, 1: asynchronous, active-low reset (0 = reset).
- `id_valid_i`, input, 1: the ID stage holds a real instruction.
- `id_rs1_i`, input, REG_AW: ID-stage source register 1.
- `id_rs2_i`, input, REG_AW: ID-stage source register 2.
- `id_rd_i`, input, REG_AW: ID-stage destination register.
- `id_regwrite_i`, input, 1: the ID instruction writes `rd`.
- `id_memread_i`, input, 1: the ID instruction is a load.
- `flush_i`, input, 1: the ID instruction is squashed (taken branch).
- `forward_a_o`, output, 2: select for the EX instruction's rs1 operand.
- `forward_b_o`, output, 2: select for the EX instruction's rs2 operand.
- `stall_o`, output, 1: hold the PC and IF/ID, and insert a bubble into EX.
- `stall_cnt_o`, output, CNT_W: count of stall cycles since reset.

## Operation
- **Tag pipeline.** The block keeps three tag registers.
  - EX tag: `{valid, rd, regwrite, memread}`.
  - MEM tag: `{valid, rd, regwrite, memread}`.
  - WB tag: `{valid, rd, regwrite}`.
  - Every cycle: WB <= MEM, MEM <= EX, EX <= ID tag or a bubble.
- **Bubble.** EX loads a bubble (valid=0) when `stall_o`, `flush_i` or `!id_valid_i` is high.
- **Load-use stall.** `stall_o = id_valid_i & !flush_i & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & (EX.rd==id_rs1_i | EX.rd==id_rs2_i)`. This is combinational from the tags and inputs.
- **Forward select.** The next value of `forward_a_o` is computed for `id_rs1_i`; `forward_b_o` uses the same rule for `id_rs2_i`. The first matching rule wins:
  - `10` if EX.valid & EX.regwrite & !EX.memread & EX.rd!=0 & EX.rd==rs. At the next edge this instruction moves to MEM.
  - `01` if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==rs. At the next edge this instruction moves to WB.
  - `00` otherwise.
- **Select registers.** The selects are registered at the edge that moves the ID instruction into EX.
  - If EX receives a bubble, both selects are registered as `00`.
  - MEM priority over WB is strict; the nearest producer always wins.
- **Register x0.** x0 is never forwarded, on either operand.
- **Stall counter.** `stall_cnt_o` increments on each cycle with `stall_o`=1 and saturates at all-ones without wrapping.
- **Flush with hazard.** `flush_i` has priority over a load-use hazard in the same cycle: no stall, a bubble enters EX, and the counter does not increment.

## Timing
- **Reset.** While `rst_i`=0:
  - All tags are invalid.
  - `forward_a_o`=`forward_b_o`=`00`.
  - `stall_cnt_o`=0.
  - `stall_o`=0, because the EX tag is invalid.
  - Reset applied mid-stall clears the stall immediately; no pending state survives it.
- **Select latency.** The forward selects are valid for the whole cycle in which their instruction occupies EX, with one cycle of latency from ID.
- **Stall latency.** `stall_o` has zero latency: it is asserted in the same cycle the dependent instruction sits in ID.
- **Load-use sequence.** A load followed by a dependent instruction produces:
  - exactly one stall cycle;
  - then select `01` for that operand, with the load now in WB.
- **Back-to-back loads.** Each load-use pair stalls independently: one cycle per pair, with no merging.
- **Same producer on both operands.** Both selects assert the same code.

## Structure
- **Package `forward_pkg`** holds:
  - the constants `FWD_NONE`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - the packed tag typedef `stage_tag_t`.
- **Sub-module `fwd_sel`.** A combinational per-operand priority compare: rs plus two tags in, 2-bit select out. It is instantiated twice. The tag registers, the stall logic and the counter live in the top-level `forward_ctrl`.

## Test plan
- **Reset.** Assert reset with random inputs. Required: selects `00`, stall 0, count 0. Then release reset.
- **EX-to-EX forward.** Issue `add x5,x1,x2` then `sub x6,x5,x3`. Required: `forward_a_o`=`10` and `forward_b_o`=`00` while `sub` is in EX.
- **Priority and distance-2 forward.**
  - Issue `add x5`, then `add x5`, then `or x7,x5,x5`. Required: both selects `10`, because MEM wins.
  - Issue `add x5`, then `nop`, then a user of x5. Required: `01`.
- **Load-use.** Issue `lw x4,0(x1)` then `add x8,x4,x4`. Required:
  - `stall_o`=1 for exactly one cycle;
  - `stall_cnt_o` goes from 0 to 1;
  - both selects `01` next cycle.
- **x0 and no-regwrite.** Writes to x0, and `sw` followed by a user of the same register index. Required: selects stay `00`.
- **Flush vs stall.** `lw x4`, then a dependent instruction with `flush_i`=1 in the same cycle. Required: `stall_o`=0, the count is unchanged, and the bubble yields `00`.
- **Counter saturation.** Force `CNT_W`=4 and run 20 stall cycles. Required: `stall_cnt_o` holds at 15.

Source files
------------

// File: rtl/forward_pkg.sv
// rtl/forward_pkg.sv - shared select codes and pipeline tag types for forward_ctrl
package forward_pkg;

  // Register index width carried in the stage tags.
  localparam int TAG_AW = 5;

  // EX-stage operand mux select codes.
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file
  localparam logic [1:0] FWD_WB   = 2'b01;  // WB write data
  localparam logic [1:0] FWD_MEM  = 2'b10;  // MEM ALU result

  // Tag for an instruction in EX or MEM.
  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_tag_t;

  // Tag for an instruction in WB; whether it was a load no longer matters there.
  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
  } wb_tag_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding priority compare
module fwd_sel
  import forward_pkg::*;
(
  input  logic [TAG_AW-1:0] i_rs,
  input  stage_tag_t        i_ex_tag,
  input  stage_tag_t        i_mem_tag,
  output logic [1:0]        o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused;

  // EX producer moves to MEM next edge; a load there has no ALU result to give.
  assign w_ex_hit = i_ex_tag.valid & i_ex_tag.regwrite & ~i_ex_tag.memread &
                    (i_ex_tag.rd != '0) & (i_ex_tag.rd == i_rs);

  // MEM producer moves to WB next edge; loads included, their data is ready there.
  assign w_mem_hit = i_mem_tag.valid & i_mem_tag.regwrite &
                     (i_mem_tag.rd != '0) & (i_mem_tag.rd == i_rs);

  // The load flag of the farther producer is irrelevant to its select.
  assign w_unused = &{1'b0, i_mem_tag.memread};

  // Nearest producer wins.
  always_comb begin
    o_sel = FWD_NONE;
    if (w_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// rtl/forward_ctrl.sv - EX operand forwarding and load-use stall controller
module forward_ctrl
  import forward_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_tag_t       r_ex;
  stage_tag_t       r_mem;
  wb_tag_t          r_wb;
  stage_tag_t       w_id_tag;
  logic             w_stall;
  logic             w_bubble;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused;

  // Load in EX feeding the ID instruction; a squashed ID instruction never stalls.
  always_comb begin
    w_stall = id_valid_i & ~flush_i & r_ex.valid & r_ex.memread & r_ex.regwrite &
              (r_ex.rd != '0) & ((r_ex.rd == id_rs1_i) | (r_ex.rd == id_rs2_i));
  end

  assign w_bubble = w_stall | flush_i | ~id_valid_i;

  // Tag presented to EX at the next edge: the ID instruction or an empty slot.
  always_comb begin
    w_id_tag = '0;
    if (!w_bubble) begin
      w_id_tag = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
    end
  end

  fwd_sel u_sel_a (
    .i_rs      (id_rs1_i),
    .i_ex_tag  (r_ex),
    .i_mem_tag (r_mem),
    .o_sel     (w_fwd_a)
  );

  fwd_sel u_sel_b (
    .i_rs      (id_rs2_i),
    .i_ex_tag  (r_ex),
    .i_mem_tag (r_mem),
    .o_sel     (w_fwd_b)
  );

  // Advance the tag pipeline one stage per cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_id_tag;
      r_mem <= r_ex;
      r_wb  <= '{valid: r_mem.valid, rd: r_mem.rd, regwrite: r_mem.regwrite};
    end
  end

  // Capture the selects as the ID instruction enters EX; a bubble reads the register file.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
    end else if (w_bubble) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
    end else begin
      r_fwd_a <= w_fwd_a;
      r_fwd_b <= w_fwd_b;
    end
  end

  // Count stall cycles, holding at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The WB tag is pipeline bookkeeping only; no select depends on it.
  assign w_unused = &{1'b0, r_wb};

  assign forward_a_o = r_fwd_a;
  assign forward_b_o = r_fwd_b;
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb/tb_forward_ctrl.sv - self-checking bench for forward_ctrl
module tb_forward_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_memread_i;
  logic        flush_i;
  logic [1:0]  forward_a_o;
  logic [1:0]  forward_b_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;
  logic [1:0]  fa4;
  logic [1:0]  fb4;
  logic        stall4;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       memread;
  } instr_t;

  // Instructions that entered EX, oldest first; last entry is in EX now.
  instr_t      hist[$];
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  bit          m_s;

  always #5 clk_i = ~clk_i;

  forward_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .forward_a_o   (forward_a_o),
    .forward_b_o   (forward_b_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  forward_ctrl #(.REG_AW(5), .CNT_W(4)) u_dut4 (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .forward_a_o   (fa4),
    .forward_b_o   (fb4),
    .stall_o       (stall4),
    .stall_cnt_o   (cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Load in EX whose result the ID instruction reads.
  function automatic bit m_stall();
    instr_t e;
    if (hist.size() == 0) return 1'b0;
    e = hist[hist.size()-1];
    return id_valid_i && !flush_i && e.valid && e.memread && e.regwrite &&
           e.rd != 5'd0 && (e.rd == id_rs1_i || e.rd == id_rs2_i);
  endfunction

  // Select for the EX instruction: look one and two slots back for its producer.
  function automatic logic [1:0] m_fwd(input bit use_rs2);
    instr_t c;
    instr_t p;
    logic [4:0] rs;
    int n;
    n = hist.size();
    if (n == 0) return 2'b00;
    c = hist[n-1];
    if (!c.valid) return 2'b00;
    rs = use_rs2 ? c.rs2 : c.rs1;
    if (rs == 5'd0) return 2'b00;
    if (n >= 2) begin
      p = hist[n-2];
      if (p.valid && p.regwrite && !p.memread && p.rd == rs) return 2'b10;
    end
    if (n >= 3) begin
      p = hist[n-3];
      if (p.valid && p.regwrite && p.rd == rs) return 2'b01;
    end
    return 2'b00;
  endfunction

  // Model state update.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist.delete();
      m_cnt  = 32'd0;
      m_cnt4 = 4'd0;
    end else begin
      m_s = m_stall();
      if (m_s) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
      if (m_s || flush_i || !id_valid_i) hist.push_back('0);
      else hist.push_back('{1'b1, id_rd_i, id_rs1_i, id_rs2_i, id_regwrite_i, id_memread_i});
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    check("fwd_a", {30'd0, forward_a_o}, {30'd0, m_fwd(1'b0)});
    check("fwd_b", {30'd0, forward_b_o}, {30'd0, m_fwd(1'b1)});
    check("stall", {31'd0, stall_o}, {31'd0, m_stall()});
    check("cnt", stall_cnt_o, m_cnt);
    check("fwd_a4", {30'd0, fa4}, {30'd0, m_fwd(1'b0)});
    check("fwd_b4", {30'd0, fb4}, {30'd0, m_fwd(1'b1)});
    check("stall4", {31'd0, stall4}, {31'd0, m_stall()});
    check("cnt4", {28'd0, cnt4}, {28'd0, m_cnt4});
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic rw, input logic mr, input logic fl);
    id_valid_i    = v;
    id_rd_i       = rd;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present an instruction, hold it through any stall, then let it enter EX.
  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rw, input logic mr);
    drive(1'b1, rd, rs1, rs2, rw, mr, 1'b0);
    for (int k = 0; k < 4 && m_stall(); k++) tick();
    tick();
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue(rd, rs1, rs2, 1'b1, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rd, input logic [4:0] rs1);
    issue(rd, rs1, 5'd0, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check("rst_fwd_a", {30'd0, forward_a_o}, 32'd0);
    check("rst_fwd_b", {30'd0, forward_b_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    idle(0);
    rst_i = 1'b1;
    idle(3);

    // add x5,x1,x2 ; sub x6,x5,x3
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd5, 5'd3);
    check("ex_ex_a", {30'd0, forward_a_o}, 32'd2);
    check("ex_ex_b", {30'd0, forward_b_o}, 32'd0);
    idle(3);

    // add x5 ; add x5 ; or x7,x5,x5 -> nearest wins on both
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd5, 5'd3, 5'd4);
    alu(5'd7, 5'd5, 5'd5);
    check("prio_a", {30'd0, forward_a_o}, 32'd2);
    check("prio_b", {30'd0, forward_b_o}, 32'd2);
    idle(3);

    // add x5 ; nop ; add x9,x5,x6
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd0, 5'd0, 5'd0);
    alu(5'd9, 5'd5, 5'd6);
    check("dist2_a", {30'd0, forward_a_o}, 32'd1);
    check("dist2_b", {30'd0, forward_b_o}, 32'd0);
    idle(3);

    // lw x4,0(x1) ; add x8,x4,x4
    ld(5'd4, 5'd1);
    drive(1'b1, 5'd8, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_stall_on", {31'd0, stall_o}, 32'd1);
    check("lu_cnt_before", stall_cnt_o, 32'd0);
    tick();
    check("lu_stall_off", {31'd0, stall_o}, 32'd0);
    check("lu_cnt_after", stall_cnt_o, 32'd1);
    tick();
    check("lu_fwd_a", {30'd0, forward_a_o}, 32'd1);
    check("lu_fwd_b", {30'd0, forward_b_o}, 32'd1);
    idle(3);

    // Writes to x0, store followed by a reader of the same index, load to x0
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd9, 5'd0, 5'd0);
    check("x0_a", {30'd0, forward_a_o}, 32'd0);
    check("x0_b", {30'd0, forward_b_o}, 32'd0);
    issue(5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
    alu(5'd10, 5'd5, 5'd5);
    check("sw_a", {30'd0, forward_a_o}, 32'd0);
    check("sw_b", {30'd0, forward_b_o}, 32'd0);
    ld(5'd0, 5'd1);
    drive(1'b1, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("ld_x0_stall", {31'd0, stall_o}, 32'd0);
    tick();
    idle(3);

    // lw x4 ; dependent instruction squashed in the same cycle
    ld(5'd4, 5'd1);
    drive(1'b1, 5'd8, 5'd4, 5'd2, 1'b1, 1'b0, 1'b1);
    #1;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("flush_cnt", stall_cnt_o, 32'd1);
    check("flush_a", {30'd0, forward_a_o}, 32'd0);
    check("flush_b", {30'd0, forward_b_o}, 32'd0);
    idle(3);

    // Twenty chained loads, each stalling once
    ld(5'd4, 5'd1);
    for (int i = 0; i < 20; i++) ld(5'd4, 5'd4);
    idle(3);
    check("sat_cnt4", {28'd0, cnt4}, 32'd15);
    check("sat_cnt32", stall_cnt_o, 32'd21);

    // Reset in the middle of a stall
    ld(5'd4, 5'd1);
    drive(1'b1, 5'd8, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    check("mid_stall_on", {31'd0, stall_o}, 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_cnt", stall_cnt_o, 32'd0);
    check("mid_rst_cnt4", {28'd0, cnt4}, 32'd0);
    tick();
    tick();
    idle(0);
    rst_i = 1'b1;
    idle(3);
    alu(5'd5, 5'd1, 5'd2);
    alu(5'd6, 5'd5, 5'd5);
    check("post_rst_a", {30'd0, forward_a_o}, 32'd2);
    check("post_rst_b", {30'd0, forward_b_o}, 32'd2);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
